// File: rtl/epl_row_sel_seq.sv
// epl_row_sel_seq: sequenced row-selection controller for the EPLFFRAM02 array.
// Accepts one read/write row request at a time, decodes bank+row into a
// one-hot wordline and times the wordline pulse with an internal counter.
// Optional feature macro: EPL_ROWSEL_RESTORE_EN -- reads append a RESTORE
// (write-back) phase after ACTIVE. Undefined: RESTORE is unreachable and
// pRestore_o is tied 0.
module epl_row_sel_seq #(
    parameter  int ROWS     = 64,
    parameter  int BANKS    = 1,
    parameter  int WL_PULSE = 4,
    parameter  int GUARD    = 2,
    localparam int AW       = $clog2(ROWS),
    localparam int BW       = ($clog2(BANKS) > 1) ? $clog2(BANKS) : 1
) (
    input  logic                  pClk_i,
    input  logic                  pRst_i,
    input  logic                  pReq_i,
    input  logic                  pWrite_i,
    input  logic [BW-1:0]         pBank_i,
    input  logic [AW-1:0]         pArx_i,
    output logic                  pReady_o,
    output logic [BANKS*ROWS-1:0] pWl_o,
    output logic                  pRead0_o,
    output logic                  pWrite0_o,
    output logic                  pRestore_o,
    output logic                  pDone_o,
    output logic                  pErr_o
);

    localparam int MAXC = (WL_PULSE > GUARD) ? WL_PULSE : GUARD;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(WL_PULSE - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD - 1);
    localparam logic [AW:0]   ROWS_LIM   = (AW+1)'(ROWS);
    localparam logic [BW:0]   BANKS_LIM  = (BW+1)'(BANKS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACTIVE  = 3'd2,
        RESTORE = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    op_write_q;
    logic [BW-1:0]           bank_q;
    logic [AW-1:0]           row_q;
    logic                    ready_q;
    logic [BANKS*ROWS-1:0]   wl_q;
    logic                    read0_q;
    logic                    write0_q;
    logic                    done_q;
    logic                    err_q;
`ifdef EPL_ROWSEL_RESTORE_EN
    logic                    restore_q;
`endif

    logic                    req_in_range;
    logic [BANKS*ROWS-1:0]   wl_d;

    // Range check: row count need not be a power of two, so compare explicitly.
    assign req_in_range = ({1'b0, pArx_i} < ROWS_LIM) && ({1'b0, pBank_i} < BANKS_LIM);

    // One-hot wordline decode from the latched bank/row; a single match per bank/row pair.
    for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign wl_d[gb*ROWS + gi] = (bank_q == BW'(gb)) && (row_q == AW'(gi));
        end
    end

    // Access sequencer: state, counter and all registered outputs in one place.
    always_ff @(posedge pClk_i or posedge pRst_i) begin
        if (pRst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            bank_q     <= '0;
            row_q      <= '0;
            ready_q    <= 1'b1;
            wl_q       <= '0;
            read0_q    <= 1'b0;
            write0_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef EPL_ROWSEL_RESTORE_EN
            restore_q  <= 1'b0;
`endif
        end else begin
            // Done and error are single-cycle pulses.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pReq_i) begin
                        if (req_in_range) begin
                            op_write_q <= pWrite_i;
                            bank_q     <= pBank_i;
                            row_q      <= pArx_i;
                            ready_q    <= 1'b0;
                            state_q    <= SETUP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    cnt_q    <= PULSE_LOAD;
                    wl_q     <= wl_d;
                    read0_q  <= ~op_write_q;
                    write0_q <= op_write_q;
                    state_q  <= ACTIVE;
                end
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
`ifdef EPL_ROWSEL_RESTORE_EN
                        if (!op_write_q) begin
                            // Destructive read: keep the wordline up and write the data back.
                            cnt_q     <= PULSE_LOAD;
                            read0_q   <= 1'b0;
                            restore_q <= 1'b1;
                            state_q   <= RESTORE;
                        end else begin
                            cnt_q    <= GUARD_LOAD;
                            wl_q     <= '0;
                            read0_q  <= 1'b0;
                            write0_q <= 1'b0;
                            state_q  <= RECOVER;
                        end
`else
                        cnt_q    <= GUARD_LOAD;
                        wl_q     <= '0;
                        read0_q  <= 1'b0;
                        write0_q <= 1'b0;
                        state_q  <= RECOVER;
`endif
                    end
                end
                RESTORE: begin
`ifdef EPL_ROWSEL_RESTORE_EN
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q     <= GUARD_LOAD;
                        wl_q      <= '0;
                        restore_q <= 1'b0;
                        state_q   <= RECOVER;
                    end
`else
                    // Unreachable in this build; fall back to a clean recovery.
                    cnt_q    <= GUARD_LOAD;
                    wl_q     <= '0;
                    read0_q  <= 1'b0;
                    write0_q <= 1'b0;
                    state_q  <= RECOVER;
`endif
                end
                RECOVER: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wl_q     <= '0;
                    read0_q  <= 1'b0;
                    write0_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign pReady_o  = ready_q;
    assign pWl_o     = wl_q;
    assign pRead0_o  = read0_q;
    assign pWrite0_o = write0_q;
    assign pDone_o   = done_q;
    assign pErr_o    = err_q;
`ifdef EPL_ROWSEL_RESTORE_EN
    assign pRestore_o = restore_q;
`else
    assign pRestore_o = 1'b0;
`endif

endmodule

// File: tb/tb_epl_row_sel_seq.sv
// Bench for epl_row_sel_seq (ROWS=48, BANKS=2, WL_PULSE=4, GUARD=2).
// Each request pushes its expected per-cycle output trace into a queue;
// a monitor pops and compares on every falling edge.
module tb_epl_row_sel_seq;

    localparam int ROWS  = 48;
    localparam int BANKS = 2;
    localparam int WL    = 4;
    localparam int GUARD = 2;
    localparam int AW    = 6;
    localparam int BW    = 1;
    localparam int NW    = BANKS * ROWS;
`ifdef EPL_ROWSEL_RESTORE_EN
    localparam bit RS_ON = 1'b1;
`else
    localparam bit RS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          wr  = 1'b0;
    logic [BW-1:0] bank = '0;
    logic [AW-1:0] row  = '0;
    logic          ready_o, rd_o, wr_o, rs_o, done_o, err_o;
    logic [NW-1:0] wl_o;

    epl_row_sel_seq #(
        .ROWS(ROWS), .BANKS(BANKS), .WL_PULSE(WL), .GUARD(GUARD)
    ) dut (
        .pClk_i(clk), .pRst_i(rst), .pReq_i(req), .pWrite_i(wr),
        .pBank_i(bank), .pArx_i(row), .pReady_o(ready_o), .pWl_o(wl_o),
        .pRead0_o(rd_o), .pWrite0_o(wr_o), .pRestore_o(rs_o),
        .pDone_o(done_o), .pErr_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NW-1:0] wl;
        logic rd, wr, rs, done, err, ready;
    } exp_t;

    typedef struct {
        bit w;
        int bank;
        int row;
        bit err;
        int bit_idx;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic exp_t idle_exp(input int c);
        exp_t e;
        e.cyc = c; e.wl = '0; e.rd = 0; e.wr = 0; e.rs = 0;
        e.done = 0; e.err = 0; e.ready = 1;
        return e;
    endfunction

    // Expected trace straight from the timing description.
    task automatic push_expect(input int t, input bit w, input int bit_idx,
                               input bit is_err, output int lat);
        exp_t e;
        int   rest_len;
        if (is_err) begin
            e = idle_exp(t + 1);
            e.err = 1;
            exp_q.push_back(e);
            lat = 1;
        end else begin
            rest_len = (RS_ON && !w) ? WL : 0;
            lat = 2 + WL + rest_len + GUARD;
            for (int k = 1; k <= lat; k++) begin
                e = idle_exp(t + k);
                e.ready = 0;
                if (k >= 2 && k <= 1 + WL) begin
                    e.wl[bit_idx] = 1'b1; e.rd = !w; e.wr = w;
                end else if (k >= 2 + WL && k <= 1 + WL + rest_len) begin
                    e.wl[bit_idx] = 1'b1; e.rs = 1;
                end
                if (k == lat) begin
                    e.done = 1; e.ready = 1;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        e = idle_exp(cyc);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_vec++; n_miss++;
            $display("FAIL stale_expect cyc=%0d: entry for cyc %0d never matched", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        n_vec++;
        if (wl_o !== e.wl || rd_o !== e.rd || wr_o !== e.wr || rs_o !== e.rs ||
            done_o !== e.done || err_o !== e.err || ready_o !== e.ready) begin
            n_miss++;
            $display("FAIL cycle_outputs cyc=%0d got wl=%h rd=%b wr=%b rs=%b done=%b err=%b rdy=%b want wl=%h rd=%b wr=%b rs=%b done=%b err=%b rdy=%b",
                     cyc, wl_o, rd_o, wr_o, rs_o, done_o, err_o, ready_o,
                     e.wl, e.rd, e.wr, e.rs, e.done, e.err, e.ready);
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #2;
        end
    endtask

    // Called at posedge+2 of the cycle in which the request is presented.
    task automatic issue(input bit w, input int b, input int r, input bit is_err,
                         input int bit_idx, output int t, output int lat);
        req = 1; wr = w; bank = BW'(b); row = AW'(r);
        t = cyc;
        push_expect(t, w, bit_idx, is_err, lat);
        $display("txn cyc=%0d %s bank=%0d row=%0d expect %s latency=%0d",
                 t, w ? "write" : "read", b, r, is_err ? "reject" : "access", lat);
        @(posedge clk); #2;
        req = 0;
    endtask

    // Request with no expectation: must be ignored while busy.
    task automatic poke(input bit w, input int b, input int r);
        req = 1; wr = w; bank = BW'(b); row = AW'(r);
        $display("txn cyc=%0d busy-request bank=%0d row=%0d expect ignored", cyc, b, r);
        @(posedge clk); #2;
        req = 0;
    endtask

    task automatic stimulus();
        int t, lat, t2, lat2, guard_n;
        vecs[0] = '{w:0, bank:0, row:5,  err:0, bit_idx:5};
        vecs[1] = '{w:1, bank:1, row:47, err:0, bit_idx:95};
        vecs[2] = '{w:0, bank:0, row:50, err:1, bit_idx:0};
        vecs[3] = '{w:0, bank:0, row:3,  err:0, bit_idx:3};
        vecs[4] = '{w:1, bank:0, row:0,  err:0, bit_idx:0};
        vecs[5] = '{w:0, bank:1, row:0,  err:0, bit_idx:48};
        vecs[6] = '{w:1, bank:0, row:47, err:0, bit_idx:47};
        vecs[7] = '{w:0, bank:1, row:63, err:1, bit_idx:0};

        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(posedge clk); #2;

        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].bank, vecs[i].row, vecs[i].err, vecs[i].bit_idx, t, lat);
            goto_cycle(t + lat + 2);
        end

        // Busy request at T+3 ignored; request in the done cycle accepted.
        issue(0, 0, 2, 0, 2, t, lat);
        goto_cycle(t + 3);
        poke(1, 0, 9);
        goto_cycle(t + lat);
        issue(0, 0, 7, 0, 7, t2, lat2);
        goto_cycle(t2 + lat2 + 2);

        // Reset mid-access clears everything asynchronously.
        issue(0, 1, 4, 0, 52, t, lat);
        goto_cycle(t + 3);
        rst = 1;
        #1;
        n_vec++;
        if (wl_o !== '0 || rd_o !== 0 || wr_o !== 0 || rs_o !== 0 ||
            done_o !== 0 || err_o !== 0 || ready_o !== 1) begin
            n_miss++;
            $display("FAIL async_reset got wl=%h rd=%b wr=%b rs=%b done=%b err=%b rdy=%b want all zero with rdy=1",
                     wl_o, rd_o, wr_o, rs_o, done_o, err_o, ready_o);
        end
        exp_q.delete();
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;
        issue(0, 0, 10, 0, 10, t, lat);
        goto_cycle(t + lat + 2);

        guard_n = 0;
        while (exp_q.size() > 0 && guard_n < 100) begin
            @(posedge clk); #2;
            guard_n++;
        end
        if (exp_q.size() > 0) begin
            n_vec++; n_miss++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                check_cycle();
            end
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/epl_row_sel_seq.md
# epl_row_sel_seq

Parametrised, sequenced row-selection controller for the EPLFFRAM02 array. It accepts one read or write row request at a time, decodes a bank and row address into a one-hot wordline, and times the wordline pulse with an internal counter. It drives the read/write phase strobes to the sense-amp and write-driver blocks and supports multiple banks and a non-power-of-two row count. For the destructive-read ferroelectric array it can append a restore (write-back) phase.

## Interface
- ROWS, 64, rows per bank (≥2, need not be a power of two)
- BANKS, 1, number of banks (≥1)
- WL_PULSE, 4, wordline-active cycles per phase (≥1)
- GUARD, 2, wordline-off recovery cycles before the next access (≥1)
- Derived: AW = $clog2(ROWS); BW = max(1, $clog2(BANKS))
- pClk_i  in  1  clock; all flops rise-edge
- pRst_i  in  1  reset, asynchronous, active-high
- pReq_i  in  1  request strobe; accepted only when pReady_o=1
- pWrite_i  in  1  1=write, 0=read; sampled with an accepted pReq_i
- pBank_i  in  BW  bank index; sampled with pReq_i
- pArx_i  in  AW  row index; sampled with pReq_i
- pReady_o  out  1  controller idle, can accept a request
- pWl_o  out  BANKS*ROWS  one-hot wordlines; bit = bank*ROWS+row
- pRead0_o  out  1  read sense phase active
- pWrite0_o  out  1  write drive phase active
- pRestore_o  out  1  restore phase active (macro-dependent)
- pDone_o  out  1  one-cycle access-complete pulse
- pErr_o  out  1  one-cycle pulse: request rejected, address out of range

## Operation
- FSM states: IDLE, SETUP, ACTIVE, RESTORE, RECOVER. All outputs are registered.
- IDLE: pReady_o=1. pReq_i with pArx_i<ROWS and pBank_i<BANKS latches op, bank and row, then goes to SETUP.
- Out-of-range request: pErr_o=1 the next cycle; FSM stays IDLE; no wordline fires.
- SETUP: one cycle; pReady_o=0; pWl_o stays all-zero; loads the counter with WL_PULSE-1.
- ACTIVE: exactly one bit of pWl_o is high. Read drives pRead0_o=1; write drives pWrite0_o=1. Lasts WL_PULSE cycles.
- RESTORE (read only, macro on): wordline stays high; pRead0_o=0; pRestore_o=1; lasts WL_PULSE cycles.
- RECOVER: pWl_o=0 and all strobes 0; lasts GUARD cycles, then IDLE.
- On entering IDLE from RECOVER: pDone_o=1 for one cycle, and pReady_o=1 in the same cycle. A request in that cycle is accepted.
- pReq_i while pReady_o=0 is ignored. There is no queue and no error.
- pWl_o is never multi-hot. A strobe is high only while a wordline is high.
- Counter width is $clog2(max(WL_PULSE,GUARD))+1 and it saturates at 0.
- Reset, including mid-access: all state clears immediately. pWl_o=0, pRead0_o=0, pWrite0_o=0, pRestore_o=0, pDone_o=0, pErr_o=0, pReady_o=1, state=IDLE.

## Timing
- Request accepted at edge T.
  - SETUP at T+1.
  - Wordline high T+2 … T+1+WL_PULSE.
  - RECOVER for GUARD cycles.
  - pDone_o at T+2+WL_PULSE+GUARD.
- Read with restore: the wordline stays high for an extra WL_PULSE cycles, giving done at T+2+2·WL_PULSE+GUARD.
- Defaults: read/write done at T+8; read with restore done at T+12.
- Error path: pErr_o at T+1, pReady_o held at 1.
- Back-to-back throughput: one access per 2+WL_PULSE+GUARD cycles.

## Configuration
- EPL_ROWSEL_RESTORE_EN defined: reads pass through RESTORE after ACTIVE.
- Not defined: RESTORE is unreachable and pRestore_o is tied 0. Reads go ACTIVE→RECOVER with the same timing as writes.
- Writes never enter RESTORE in either build.

## Test plan
- Reset then read, defaults, bank 0 row 5, macro off:
  - pWl_o[5]=1 at T+2…T+5.
  - pRead0_o matches that window.
  - pDone_o at T+8; pReady_o=1 at T+8.
- Write, BANKS=2, ROWS=48, bank 1 row 47:
  - pWl_o[95]=1 at T+2…T+5.
  - pWrite0_o high in the same window.
  - pRead0_o=0 throughout.
- Out-of-range row, ROWS=48, pArx_i=50:
  - pErr_o pulse at T+1.
  - pWl_o=0 throughout.
  - pReady_o stays 1.
- Macro on, read row 3:
  - pWl_o[3] high T+2…T+9.
  - pRead0_o T+2…T+5, then pRestore_o T+6…T+9.
  - pDone_o at T+12.
- Requests at T+3 (ignored) and at T+8 (the done cycle, accepted, row 7):
  - pWl_o[7] high T+10…T+13.
- pRst_i asserted at T+3 mid-access: all outputs 0 and pReady_o=1 asynchronously; a new read after release completes normally.
